// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter for NUM_REQ channels with optional burst retention.
// The winning channel's data is registered onto a single valid/ready output.
module rr_req_gnt_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 1,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     last, last_nxt;
    logic [CNT_W-1:0]    burst_cnt, burst_cnt_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic                valid_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic [ID_W-1:0]     id_nxt;

    logic                retain;
    logic [ID_W-1:0]     start_idx;
    logic [ID_W-1:0]     win;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (int'(c) >= MAX_BURST)
            return CNT_W'(MAX_BURST);
        return c + 1'b1;
    endfunction

    // A zero count means nobody holds priority yet, so the scan starts after last.
    assign retain = (burst_cnt != '0) && (int'(burst_cnt) < MAX_BURST);

    always_comb begin
        start_idx = last;
        if (!retain)
            start_idx = (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
    end

    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(start_idx) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        burst_cnt_nxt = burst_cnt;
        gnt_nxt       = '0;
        valid_nxt     = out_valid;
        data_nxt      = out_data;
        id_nxt        = out_id;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt     = HOLD;
                    gnt_nxt[win]  = 1'b1;
                    valid_nxt     = 1'b1;
                    data_nxt      = data[int'(win)*DATA_W +: DATA_W];
                    id_nxt        = win;
                    last_nxt      = win;
                    // Forced rotation or a new winner restarts the burst count.
                    burst_cnt_nxt = (retain && win == last) ? sat_inc(burst_cnt) : CNT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= ID_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_cnt_nxt;
            gnt       <= gnt_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_id    <= id_nxt;
        end
    end

    assign busy = (state == HOLD);

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Bench for rr_req_gnt_arbiter: three instances (MAX_BURST 1, 3, 2) share stimulus
// and are each compared every cycle against a transfer-level reference model.
module tb_rr_req_gnt_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NI = 3;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] data;
    logic          out_ready;

    logic [N-1:0]  gnt_o   [NI];
    logic          valid_o [NI];
    logic [DW-1:0] data_o  [NI];
    logic [1:0]    id_o    [NI];
    logic          busy_o  [NI];

    int total = 0;
    int bad   = 0;

    // Model state per instance
    int            mb      [NI];
    int            m_last  [NI];
    int            m_run   [NI];
    bit            m_hold  [NI];
    logic [N-1:0]  m_gnt   [NI];
    bit            m_valid [NI];
    logic [DW-1:0] m_data  [NI];
    int            m_id    [NI];

    rr_req_gnt_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(1)) u_rr (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .gnt(gnt_o[0]), .out_valid(valid_o[0]), .out_data(data_o[0]), .out_id(id_o[0]),
        .out_ready(out_ready), .busy(busy_o[0]));

    rr_req_gnt_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(3)) u_b3 (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .gnt(gnt_o[1]), .out_valid(valid_o[1]), .out_data(data_o[1]), .out_id(id_o[1]),
        .out_ready(out_ready), .busy(busy_o[1]));

    rr_req_gnt_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(2)) u_b2 (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .gnt(gnt_o[2]), .out_valid(valid_o[2]), .out_data(data_o[2]), .out_id(id_o[2]),
        .out_ready(out_ready), .busy(busy_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_last[k]  = N - 1;
            m_run[k]   = 0;
            m_hold[k]  = 0;
            m_gnt[k]   = '0;
            m_valid[k] = 0;
            m_data[k]  = '0;
            m_id[k]    = 0;
        end
    endtask

    // One transfer decision per instance: who owns priority, where the search begins,
    // and how long the current owner's run of consecutive grants has been.
    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            m_gnt[k] = '0;
            if (m_hold[k]) begin
                if (out_ready) begin
                    m_valid[k] = 0;
                    m_hold[k]  = 0;
                end
            end else if (req != '0) begin
                bit keep;
                int s, w;
                keep = (m_run[k] > 0) && (m_run[k] < mb[k]);
                s = keep ? m_last[k] : (m_last[k] + 1) % N;
                w = -1;
                for (int j = 0; j < N; j++)
                    if (w < 0 && req[(s + j) % N]) w = (s + j) % N;
                m_run[k]   = (keep && w == m_last[k]) ? m_run[k] + 1 : 1;
                m_last[k]  = w;
                m_gnt[k]   = N'(1) << w;
                m_valid[k] = 1;
                m_data[k]  = data[w*DW +: DW];
                m_id[k]    = w;
                m_hold[k]  = 1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_i%0d_gnt", ph, k),   32'(gnt_o[k]),   32'(m_gnt[k]));
            chk($sformatf("%s_i%0d_valid", ph, k), 32'(valid_o[k]), 32'(m_valid[k]));
            chk($sformatf("%s_i%0d_data", ph, k),  32'(data_o[k]),  32'(m_data[k]));
            chk($sformatf("%s_i%0d_id", ph, k),    32'(id_o[k]),    32'(m_id[k]));
            chk($sformatf("%s_i%0d_busy", ph, k),  32'(busy_o[k]),  32'(m_hold[k]));
        end
    endtask

    // Called at a negedge: drive inputs, advance the model across the coming posedge, compare.
    task automatic cycle(input string ph, input logic [N-1:0] r, input logic [N*DW-1:0] d,
                         input logic rdy);
        req = r;
        data = d;
        out_ready = rdy;
        model_step();
        @(negedge clk);
        check_all(ph);
    endtask

    initial begin
        mb[0] = 1; mb[1] = 3; mb[2] = 2;
        rst = 1'b1;
        req = '0;
        data = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // First transfer after reset with all channels requesting goes to channel 0.
        cycle("first", 4'b1111, 32'h44332211, 1'b1);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("first_id_i%0d", k), 32'(id_o[k]), 32'd0);
            chk($sformatf("first_data_i%0d", k), 32'(data_o[k]), 32'h11);
        end

        for (int i = 0; i < 16; i++) cycle("rr", 4'b1111, $urandom, 1'b1);

        // Backpressure: grant then hold off the slave.
        cycle("bp", 4'b1111, $urandom, 1'b1);
        for (int i = 0; i < 6; i++) cycle("bp", 4'b1111, $urandom, 1'b0);
        for (int i = 0; i < 4; i++) cycle("bp", 4'b1111, $urandom, 1'b1);

        for (int i = 0; i < 16; i++) cycle("burst", 4'b0011, $urandom, 1'b1);
        for (int i = 0; i < 6; i++)  cycle("drop", 4'b0010, $urandom, 1'b1);

        for (int i = 0; i < 4; i++) cycle("sparse", 4'b0100, 32'h00CC0000, 1'b1);
        for (int i = 0; i < 4; i++) cycle("wrap", 4'b0001, 32'h000000A5, 1'b1);

        for (int i = 0; i < 12; i++) cycle("single", 4'b0100, $urandom, 1'b1);

        for (int i = 0; i < 600; i++)
            cycle("rand", N'($urandom), $urandom, ($urandom_range(0, 3) != 0));

        // Reset while every instance holds a transfer.
        cycle("pre", 4'b1111, $urandom, 1'b1);
        cycle("pre", 4'b1111, $urandom, 1'b0);
        cycle("pre", 4'b1111, $urandom, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        rst = 1'b0;
        check_all("midrst2");
        cycle("post", 4'b1111, 32'h8877665A, 1'b1);
        for (int k = 0; k < NI; k++)
            chk($sformatf("post_id_i%0d", k), 32'(id_o[k]), 32'd0);
        for (int i = 0; i < 10; i++) cycle("post", 4'b1111, $urandom, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
